// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-back control field indices and datapath defaults.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/retire_counter.sv
// Free-running wrap-around counter of retired instructions; increments when inc is high.
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back data select and EX forwarding export.
// Retired-instruction counter is built only when MEM_WB_RETIRE_CNT_EN is defined.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] MemOp,
    input  logic [DATA_W-1:0] ResultRType,
    input  logic [REG_AW-1:0] WriteReg,
    input  logic [1:0]        WBReg,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              wb_valid,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired_count
);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] wraddr_q, wraddr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              capture;

    assign capture = !flush && !stall;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wraddr_d   = wraddr_q;
        wrdata_d   = wrdata_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            wraddr_d   = '0;
            wrdata_d   = '0;
        end else if (!stall) begin
            valid_d    = in_valid;
            wraddr_d   = WriteReg;
            wrdata_d   = WBReg[WB_MEMTOREG] ? MemOp : ResultRType;
            // $0 is hard-wired; address and data are still captured for debug visibility.
            regwrite_d = in_valid && WBReg[WB_REGWRITE] && (WriteReg != REG_AW'(REG_ZERO));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
        end
    end

    assign wb_valid = valid_q;
    assign RegWrite = regwrite_q;
    assign WrAddr   = wraddr_q;
    assign WrData   = wrdata_q;
    assign fwd_en   = regwrite_q;
    assign fwd_reg  = wraddr_q;
    assign fwd_data = wrdata_q;

`ifdef MEM_WB_RETIRE_CNT_EN
    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (capture && in_valid),
        .count(retired_count)
    );
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign retired_count  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; counter checks expect 0 unless
// MEM_WB_RETIRE_CNT_EN is defined (then CNT_W=4 to exercise wrap).
module tb_mem_wb_stage;

`ifdef MEM_WB_RETIRE_CNT_EN
    localparam int unsigned CNT_W = 4;
`else
    localparam int unsigned CNT_W = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] MemOp = '0;
    logic [31:0] ResultRType = '0;
    logic [4:0]  WriteReg = '0;
    logic [1:0]  WBReg = '0;
    logic        RegWrite;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        wb_valid;
    logic        fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [CNT_W-1:0] retired_count;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [31:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W(32),
        .REG_AW(5),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .MemOp        (MemOp),
        .ResultRType  (ResultRType),
        .WriteReg     (WriteReg),
        .WBReg        (WBReg),
        .RegWrite     (RegWrite),
        .WrAddr       (WrAddr),
        .WrData       (WrData),
        .wb_valid     (wb_valid),
        .fwd_en       (fwd_en),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data),
        .retired_count(retired_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, take one rising edge, sample 1 ns later.
    task automatic step(input logic v, input logic [1:0] wb, input logic [31:0] mem,
                        input logic [31:0] res, input logic [4:0] wr,
                        input logic st, input logic fl);
        @(negedge clk);
        in_valid = v; WBReg = wb; MemOp = mem; ResultRType = res; WriteReg = wr;
        stall = st; flush = fl;
        @(posedge clk);
        #1;
`ifdef MEM_WB_RETIRE_CNT_EN
        if (v && !st && !fl) exp_cnt = (exp_cnt + 1) & ((32'd1 << CNT_W) - 1);
`endif
    endtask

    task automatic check_out(input string tag, input logic rw, input logic [4:0] wa,
                             input logic [31:0] wd, input logic vld);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(rw));
        check({tag, ".WrAddr"},   32'(WrAddr),   32'(wa));
        check({tag, ".WrData"},   WrData,        wd);
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'(vld));
        check({tag, ".fwd_en"},   32'(fwd_en),   32'(rw));
        check({tag, ".fwd_reg"},  32'(fwd_reg),  32'(wa));
        check({tag, ".fwd_data"}, fwd_data,      wd);
        check({tag, ".retired"},  32'(retired_count), exp_cnt);
    endtask

    initial begin
        #12;
        check_out("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, 2'b11, 32'hDEADBEEF, 32'h100, 5'd8, 1'b0, 1'b0);
        check_out("load", 1'b1, 5'd8, 32'hDEADBEEF, 1'b1);

        step(1'b1, 2'b10, 32'h1234, 32'h5, 5'd3, 1'b0, 1'b0);
        check_out("rtype", 1'b1, 5'd3, 32'h5, 1'b1);

        step(1'b1, 2'b10, 32'h1234, 32'h5, 5'd0, 1'b0, 1'b0);
        check_out("reg0", 1'b0, 5'd0, 32'h5, 1'b1);

        step(1'b0, 2'b11, 32'hCAFE, 32'h9, 5'd9, 1'b0, 1'b0);
        check_out("bubble", 1'b0, 5'd9, 32'hCAFE, 1'b0);

        step(1'b1, 2'b10, 32'h0, 32'h77, 5'd7, 1'b0, 1'b0);
        check_out("pre_stall", 1'b1, 5'd7, 32'h77, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b11, 32'hAA + i, 32'hBB, 5'd12, 1'b1, 1'b0);
            check_out("stall", 1'b1, 5'd7, 32'h77, 1'b1);
        end

        step(1'b1, 2'b11, 32'h1111, 32'h2222, 5'd4, 1'b1, 1'b1);
        check_out("flush", 1'b0, 5'd0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of a cycle with a live write in WB.
        step(1'b1, 2'b10, 32'h0, 32'h3C, 5'd6, 1'b0, 1'b0);
        check_out("pre_rst", 1'b1, 5'd6, 32'h3C, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        check_out("async_rst", 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Sixteen counted captures; with CNT_W=4 the counter wraps back to 0.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'b10, 32'h0, 32'(i), 5'd1, 1'b0, 1'b0);
        end
        check_out("wrap16", 1'b1, 5'd1, 32'd15, 1'b1);
        step(1'b0, 2'b10, 32'h0, 32'h55, 5'd2, 1'b0, 1'b0);
        check_out("wrap_bubble", 1'b0, 5'd2, 32'h55, 1'b0);
        step(1'b1, 2'b11, 32'h99, 32'h55, 5'd2, 1'b0, 1'b0);
        check_out("post_wrap", 1'b1, 5'd2, 32'h99, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back select for the 5-stage MIPS pipeline.
- Sits directly downstream of the memory stage (Stage4). Consumes its MemOp, ResultRType, WriteReg and WBReg outputs.
- Registers them once, selects the write-back data, and drives the register-file write port.
- Also exports the same registered values as an EX-stage forwarding source.

Parameters:
- DATA_W, 32, width of the data path and write-back data.
- REG_AW, 5, register-file address width.
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold the current contents of the MEM/WB register.
- flush  in  1  insert a bubble into the MEM/WB register.
- in_valid  in  1  the MEM-stage instruction is real (not a bubble).
- MemOp  in  DATA_W  load data from the data memory.
- ResultRType  in  DATA_W  ALU result passed through from MEM.
- WriteReg  in  REG_AW  destination register.
- WBReg  in  2  write-back control: bit1 = RegWrite, bit0 = MemtoReg.
- RegWrite  out  1  register-file write enable.
- WrAddr  out  REG_AW  register-file write address.
- WrData  out  DATA_W  register-file write data.
- wb_valid  out  1  the WB slot holds a real instruction.
- fwd_en  out  1  forwarding source valid; equals RegWrite.
- fwd_reg  out  REG_AW  forwarding register number; equals WrAddr.
- fwd_data  out  DATA_W  forwarding data; equals WrData.
- retired_count  out  CNT_W  number of retired instructions (optional feature).

Behaviour:
- Latency: exactly 1 cycle from the MEM inputs to the WB outputs. No combinational path from inputs to outputs.
- Reset (asynchronous, active-high): RegWrite, wb_valid, WrAddr, WrData and retired_count go to 0. The fwd_* outputs follow and are therefore also 0.
- Reset asserted mid-operation discards the in-flight instruction with no write.
- Per rising edge, priority is flush > stall > capture.
- Flush:
  - wb_valid=0 and RegWrite=0.
  - WrAddr and WrData are cleared to 0.
- Stall with no flush:
  - All registers hold.
  - A held RegWrite=1 is re-presented. Repeated writes of the same value are harmless.
- Capture:
  - wb_valid <= in_valid.
  - WrAddr <= WriteReg.
  - WrData <= WBReg[0] ? MemOp : ResultRType.
  - RegWrite <= in_valid & WBReg[1] & (WriteReg != 0).
- Register $0: writes are always suppressed. WrAddr and WrData are still captured for debug.
- Bubble (in_valid=0): RegWrite=0 regardless of WBReg.
- The fwd_* outputs are continuous copies of RegWrite, WrAddr and WrData.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - retired_count increments by 1 on every capture edge with in_valid=1.
  - Not incremented on stall, flush or bubble edges.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared by reset.
- Undefined: no counter logic. retired_count is tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - WB field indices: WB_REGWRITE=1, WB_MEMTOREG=0.
  - REG_ZERO = 5'd0.
  - DATA_W and REG_AW defaults.
- One natural sub-module, retire_counter, instantiated only under MEM_WB_RETIRE_CNT_EN. Ports: clk, reset, inc, count.
- The mux and the pipeline register stay in mem_wb_stage.

Test Plan:
- Async reset: assert reset mid-cycle while RegWrite=1 -> all outputs 0 immediately, before the next clk edge.
- Load capture: in_valid=1, WBReg=2'b11, MemOp=0xDEADBEEF, ResultRType=0x100, WriteReg=8 -> next cycle RegWrite=1, WrAddr=8, WrData=0xDEADBEEF, fwd_en=1.
- R-type and $0:
  - in_valid=1, WBReg=2'b10, ResultRType=0x5, WriteReg=3 -> WrData=0x5, RegWrite=1.
  - Same with WriteReg=0 -> RegWrite=0, wb_valid=1.
- Stall: capture WriteReg=7, then stall=1 for 3 cycles with new inputs applied -> WrAddr stays 7 and WrData unchanged; retired_count +1 total.
- Flush over stall: stall=1 and flush=1 together with valid inputs -> next cycle wb_valid=0, RegWrite=0, WrAddr=0, WrData=0.
- Counter wrap (MEM_WB_RETIRE_CNT_EN, CNT_W=4): 16 valid captures from reset -> retired_count=0; a bubble edge leaves it unchanged.
